// File: rtl/pc_sequencer.sv
// Program counter owner and fetch/execute sequencer for the MIPS datapath.
// Picks the next PC, traps to the exception vector, supports halt/resume and counts retired instructions.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR    = 32'h8000_0180,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_ack,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exc_req,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] address,
    output logic        imem_req,
    output logic        instr_valid,
    output logic        halted,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic [31:0] instret
);

    // state    | meaning
    // ST_IDLE  | one cycle after reset release, PC holds RESET_VECTOR
    // ST_FETCH | imem_req high, waiting for imem_ack or fetch timeout
    // ST_EXEC  | instruction valid for one cycle, next PC chosen at its edge
    // ST_HALT  | PC frozen until resume
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam int CW = $clog2(FETCH_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_TC = CW'(FETCH_TIMEOUT - 1);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [31:0]    address_nxt, epc_nxt, instret_nxt;
    logic [1:0]     cause_nxt;
    logic           trap;
    logic [1:0]     trap_cause;
    logic           sel_hit;
    logic [31:0]    sel_tgt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            address <= RESET_VECTOR;
            epc     <= 32'd0;
            cause   <= 2'd0;
            instret <= 32'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            address <= address_nxt;
            epc     <= epc_nxt;
            cause   <= cause_nxt;
            instret <= instret_nxt;
        end
    end

    // Register jump outranks jump, which outranks branch.
    assign sel_hit = jr | jump | branch_taken;
    assign sel_tgt = jr ? jr_target : (jump ? jump_target : branch_target);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        address_nxt = address;
        epc_nxt     = epc;
        cause_nxt   = cause;
        instret_nxt = instret;
        trap        = 1'b0;
        trap_cause  = 2'd0;
        case (state)
            ST_IDLE: state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    state_nxt = ST_EXEC;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_TC) begin
                    trap       = 1'b1;
                    trap_cause = 2'd3;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_EXEC: begin
                if (exc_req) begin
                    trap       = 1'b1;
                    trap_cause = 2'd1;
                    state_nxt  = ST_FETCH;
                end else if (sel_hit && (sel_tgt[1:0] != 2'b00)) begin
                    trap       = 1'b1;
                    trap_cause = 2'd2;
                    state_nxt  = ST_FETCH;
                end else begin
                    address_nxt = sel_hit ? sel_tgt : address + 32'd4;
                    instret_nxt = instret + 32'd1;
                    state_nxt   = halt_req ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                if (resume) state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (trap) begin
            epc_nxt     = address;
            cause_nxt   = trap_cause;
            address_nxt = EXC_VECTOR;
        end
    end

    assign imem_req    = (state == ST_FETCH);
    assign instr_valid = (state == ST_EXEC);
    assign halted      = (state == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch/execute rules.
module tb_pc_sequencer;
    localparam logic [31:0] EXC = 32'h8000_0180;
    localparam int TO = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic imem_ack = 1'b0, branch_taken = 1'b0, jump = 1'b0, jr = 1'b0;
    logic exc_req = 1'b0, halt_req = 1'b0, resume = 1'b0;
    logic [31:0] branch_target = 32'd0, jump_target = 32'd0, jr_target = 32'd0;
    logic [31:0] address, epc, instret;
    logic        imem_req, instr_valid, halted;
    logic [1:0]  cause;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clock(clock), .reset(reset), .imem_ack(imem_ack),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .jr(jr), .jr_target(jr_target),
        .exc_req(exc_req), .halt_req(halt_req), .resume(resume),
        .address(address), .imem_req(imem_req), .instr_valid(instr_valid),
        .halted(halted), .epc(epc), .cause(cause), .instret(instret)
    );

    always #5 clock = ~clock;

    // Reference model: phase 0 idle, 1 fetching, 2 executing, 3 halted.
    int          m_phase;
    int          m_wait;
    logic [31:0] m_addr, m_epc, m_instret, m_tgt;
    logic [1:0]  m_cause;
    logic        m_has_tgt;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_wait = 0; m_addr = 32'd0; m_epc = 32'd0;
            m_cause = 2'd0; m_instret = 32'd0;
        end else begin
            case (m_phase)
                0: m_phase = 1;
                1: begin
                    if (imem_ack) begin
                        m_phase = 2; m_wait = 0;
                    end else begin
                        m_wait = m_wait + 1;
                        if (m_wait == TO) begin
                            m_wait = 0; m_epc = m_addr; m_cause = 2'd3; m_addr = EXC;
                        end
                    end
                end
                2: begin
                    m_has_tgt = jr || jump || branch_taken;
                    m_tgt = jr ? jr_target : jump ? jump_target : branch_target;
                    if (exc_req) begin
                        m_epc = m_addr; m_cause = 2'd1; m_addr = EXC; m_phase = 1;
                    end else if (m_has_tgt && (m_tgt % 4 != 0)) begin
                        m_epc = m_addr; m_cause = 2'd2; m_addr = EXC; m_phase = 1;
                    end else begin
                        m_addr = m_has_tgt ? m_tgt : m_addr + 32'd4;
                        m_instret = m_instret + 32'd1;
                        m_phase = halt_req ? 3 : 1;
                    end
                end
                default: if (resume) m_phase = 1;
            endcase
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clr_ctl;
        branch_taken = 0; jump = 0; jr = 0; exc_req = 0; halt_req = 0; resume = 0;
    endtask

    task automatic do_reset;
        reset = 1; clr_ctl(); imem_ack = 0;
        tick(); tick();
        reset = 0;
    endtask

    task automatic goto_exec;
        int n = 0;
        imem_ack = 1;
        while (!instr_valid && n < 50) begin
            tick(); n++;
        end
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL goto_exec bound expired instr_valid=%b expected 1", instr_valid);
        end
    endtask

    task automatic test_reset;
        reset = 1; #2;
        checks++;
        if ({address, epc, instret, cause, imem_req, instr_valid, halted} !== {32'h0, 32'h0, 32'h0, 2'b0, 3'b0}) begin
            errors++;
            $display("FAIL reset_values addr=%h epc=%h instret=%0d cause=%0d req=%b val=%b halt=%b expected all zero",
                     address, epc, instret, cause, imem_req, instr_valid, halted);
        end
        tick(); reset = 0;
        tick();
        checks++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL idle_to_fetch imem_req=%b expected 1", imem_req);
        end
    endtask

    task automatic test_sequential;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            goto_exec();
            checks++;
            if (address !== 32'(4 * i) || address !== m_addr) begin
                errors++;
                $display("FAIL seq_addr[%0d] got=%h expected=%h", i, address, 32'(4 * i));
            end
            if (i == 3) begin
                checks++;
                if (instret !== 32'd3) begin
                    errors++; $display("FAIL seq_instret got=%0d expected 3", instret);
                end
            end
            tick();
        end
    endtask

    task automatic test_priority;
        do_reset();
        goto_exec(); tick();
        goto_exec(); tick();
        goto_exec();
        jump = 1; jump_target = 32'h40; branch_taken = 1; branch_target = 32'h100;
        tick(); clr_ctl();
        checks++;
        if (address !== 32'h40 || instret !== 32'd3) begin
            errors++; $display("FAIL prio_jump addr=%h instret=%0d expected 00000040/3", address, instret);
        end
        goto_exec(); tick();
        goto_exec();
        jr = 1; jr_target = 32'h42;
        tick(); clr_ctl();
        checks++;
        if (address !== EXC || epc !== 32'h44 || cause !== 2'd2 || instret !== 32'd4) begin
            errors++;
            $display("FAIL misaligned_jr addr=%h epc=%h cause=%0d instret=%0d expected %h/00000044/2/4",
                     address, epc, cause, instret, EXC);
        end
    endtask

    task automatic test_timeout;
        int bad = 0;
        do_reset();
        goto_exec();
        jump = 1; jump_target = 32'h20;
        tick(); clr_ctl();
        imem_ack = 0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            checks++;
            if (imem_req !== 1'b1 || address !== 32'h20) begin
                errors++;
                $display("FAIL timeout_wait[%0d] req=%b addr=%h expected 1/00000020", i, imem_req, address);
            end
        end
        tick();
        checks++;
        if (address !== EXC || epc !== 32'h20 || cause !== 2'd3 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL timeout_trap addr=%h epc=%h cause=%0d req=%b expected %h/00000020/3/1",
                     address, epc, cause, imem_req, EXC);
        end
    endtask

    task automatic test_exc_halt;
        do_reset();
        goto_exec();
        jump = 1; jump_target = 32'h10;
        tick(); clr_ctl();
        goto_exec();
        exc_req = 1; halt_req = 1;
        tick(); clr_ctl();
        checks++;
        if (address !== EXC || epc !== 32'h10 || cause !== 2'd1 || halted !== 1'b0 ||
            imem_req !== 1'b1 || instret !== 32'd1) begin
            errors++;
            $display("FAIL exc_over_halt addr=%h epc=%h cause=%0d halted=%b req=%b instret=%0d expected %h/00000010/1/0/1/1",
                     address, epc, cause, halted, imem_req, instret, EXC);
        end
    endtask

    task automatic test_halt;
        do_reset();
        goto_exec();
        halt_req = 1;
        tick(); clr_ctl();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (halted !== 1'b1 || address !== 32'h4 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold[%0d] halted=%b addr=%h req=%b expected 1/00000004/0", i, halted, address, imem_req);
            end
            exc_req = 1'($urandom_range(0, 1)); halt_req = 1'($urandom_range(0, 1));
            tick();
        end
        clr_ctl();
        resume = 1;
        tick(); resume = 0;
        checks++;
        if (imem_req !== 1'b1 || halted !== 1'b0 || address !== 32'h4 || cause !== 2'd0) begin
            errors++;
            $display("FAIL resume req=%b halted=%b addr=%h cause=%0d expected 1/0/00000004/0", imem_req, halted, address, cause);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        goto_exec();
        jump = 1; jump_target = 32'h24;
        tick(); clr_ctl(); imem_ack = 0;
        tick();
        reset = 1; #2;
        checks++;
        if ({address, epc, instret, cause, imem_req, instr_valid, halted} !== {32'h0, 32'h0, 32'h0, 2'b0, 3'b0}) begin
            errors++;
            $display("FAIL async_reset_fetch addr=%h instret=%0d req=%b expected 0/0/0", address, instret, imem_req);
        end
        reset = 0;
        goto_exec();
        #2 reset = 1; #1;
        checks++;
        if (instr_valid !== 1'b0 || address !== 32'h0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_exec val=%b addr=%h req=%b expected 0/0/0", instr_valid, address, imem_req);
        end
        reset = 0;
        goto_exec();
        jump = 1; jump_target = 32'hFFFF_FFFC;
        tick(); clr_ctl();
        goto_exec();
        tick();
        checks++;
        if (address !== 32'h0 || instret !== 32'd2) begin
            errors++; $display("FAIL pc_wrap addr=%h instret=%0d expected 00000000/2", address, instret);
        end
    endtask

    task automatic test_random;
        logic [31:0] t;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            imem_ack = (i % 200 < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
            exc_req      = ($urandom_range(0, 7) == 0);
            halt_req     = ($urandom_range(0, 7) == 0);
            resume       = ($urandom_range(0, 3) == 0);
            jr           = ($urandom_range(0, 5) == 0);
            jump         = ($urandom_range(0, 4) == 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            t = $urandom; if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00; jr_target = t;
            t = $urandom; if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00; jump_target = t;
            t = $urandom; if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00; branch_target = t;
            tick();
            checks++;
            if (address !== m_addr || epc !== m_epc || cause !== m_cause || instret !== m_instret ||
                imem_req !== (m_phase == 1) || instr_valid !== (m_phase == 2) || halted !== (m_phase == 3)) begin
                errors++;
                $display("FAIL random[%0d] addr=%h/%h epc=%h/%h cause=%0d/%0d instret=%0d/%0d req=%b val=%b halt=%b phase=%0d",
                         i, address, m_addr, epc, m_epc, cause, m_cause, instret, m_instret,
                         imem_req, instr_valid, halted, m_phase);
            end
        end
        clr_ctl();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_priority();
        test_timeout();
        test_exc_halt();
        test_halt();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
